conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
- Upstream feeder for the 7x7 convolution core `con`.
- Accepts a raster-order pixel stream over a valid/ready handshake and keeps K-1 line buffers.
- Each time a full KxK window is available, presents it on `win` with a one-cycle `win_enable` pulse, then stalls input until the core returns `valid`.
- Produces one window per core transaction, in output raster order.

Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- K, 7, kernel size; must match the core (K*K = 49 lanes)
- PIX_W, 8, pixel width in bits

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a frame; ignored while busy
- pix_in  in  PIX_W  pixel data (unsigned), raster order
- pix_valid  in  1  pixel present
- pix_ready  out  1  block accepts a pixel; a transfer occurs when pix_valid & pix_ready
- win  out  K*K*PIX_W  window; lane i = ky*K+kx at win[i*PIX_W +: PIX_W]; ky=0 is the top row, kx=0 is the left column; drives core `ima`
- win_enable  out  1  one-cycle pulse; drives core `enable`
- core_valid  in  1  core `valid`; result accepted
- win_row  out  $clog2(IMG_H-K+1)  output-row index of the current window
- win_col  out  $clog2(IMG_W-K+1)  output-column index of the current window
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last window is acknowledged
- stall_cycles  out  32  WAIT-cycle counter (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; row/col counters 0. Line-buffer contents are don't-care. No window may issue before K-1 rows of the new frame have been written.
- States and transitions:
  - IDLE: start=1 -> FILL. busy=1 from the next cycle.
  - FILL: pix_ready=1. Accepting pixel (r,c) writes the line buffer and shifts the KxK window register left by one column; the new right column is rows r-K+1..r-1 at column c plus pix_in. If r>=K-1 and c>=K-1 -> ISSUE; otherwise stay in FILL.
  - ISSUE (one cycle): win_enable=1; win, win_row=r-K+1, win_col=c-K+1 are valid. -> WAIT.
  - WAIT: win, win_row, win_col held stable. core_valid=1 -> FILL, or -> DONE if (r,c)=(IMG_H-1,IMG_W-1).
  - DONE (one cycle): done=1, busy=0 -> IDLE.
- pix_ready=1 only in FILL, so at most one core transaction is outstanding.
- Latency:
  - Pixel completing a window accepted at cycle t -> win_enable=1 at t+1.
  - pix_ready=0 from t+1.
  - core_valid seen at cycle u -> pix_ready=1 at u+1.
- Line buffer: K-1 rows x IMG_W x PIX_W. Row r writes slot r mod (K-1). All windows ending in row r-1 are acknowledged before row r pixels are accepted, so no live data is overwritten.
- Column counter wraps IMG_W-1 -> 0 and increments the row counter. The window register is refilled within K columns after each wrap. Windows are issued only at c>=K-1, so stale columns are never issued.
- core_valid outside WAIT (including during ISSUE) is ignored.
- pix_valid while pix_ready=0 is ignored; the pixel is not consumed.
- start outside IDLE is ignored.
- Total windows per frame: (IMG_H-K+1)*(IMG_W-K+1), which is 484 at the defaults.

Optional Feature:
- Macro: CONV_WIN_PERF_CNT_EN.
- Defined: stall_cycles counts cycles spent in WAIT. Cleared on reset and on start accepted in IDLE. Saturates at 2^32-1.
- Undefined: stall_cycles tied to 0 and no counter logic is present.

Decomposition:
- Package conv_win_pkg:
  - state enum {IDLE, FILL, ISSUE, WAIT, DONE}
  - default constants K, PIX_W
  - localparam helper for window count
- Sub-module conv_line_buf: circular K-1 row buffer. Write port (row slot, col, data); read port returns the K-1 column pixels at col, oldest row first.

Test Plan:
- Pixels p(r,c)=r*8+c, parameters IMG_W=IMG_H=8, K=7, core_valid returned 3 cycles after each win_enable:
  - exactly 4 win_enable pulses;
  - first window has win lane0=0, lane48=54, (win_row,win_col)=(0,0);
  - second window has lane0=1, col=1;
  - fourth window has lane0=9, lane48=63;
  - done pulses once after the 4th core_valid.
- Same stimulus, core_valid delayed 10 cycles -> pix_ready=0 for 11 cycles after acceptance; win bit-stable throughout WAIT; pix_valid held high is not consumed.
- core_valid pulsed during ISSUE and during FILL -> ignored; transaction count and ordering unchanged.
- rst_n low mid-frame after window 2 -> all outputs 0 immediately; a new start plus a full frame yields 4 correct windows with no stale data.
- start pulsed while busy -> no effect; frame completes normally with 4 windows.
- CONV_WIN_PERF_CNT_EN defined, 10-cycle core delay, 4 windows -> stall_cycles=40 at done. Undefined -> stall_cycles=0.

Source files
------------

// File: rtl/conv_win_pkg.sv
// rtl/conv_win_pkg.sv - shared constants, FSM state codes and window-count helper for conv_window_gen
package conv_win_pkg;

  localparam int CONV_K     = 7;
  localparam int CONV_PIX_W = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Valid (no-padding) windows produced for one frame.
  function automatic int win_count(input int img_w, input int img_h, input int k);
    return (img_h - k + 1) * (img_w - k + 1);
  endfunction

endpackage

// File: rtl/conv_line_buf.sv
// rtl/conv_line_buf.sv - circular K-1 row line buffer; read returns one column, oldest row first
module conv_line_buf #(
  parameter int IMG_W = 28,
  parameter int K     = 7,
  parameter int PIX_W = 8,
  localparam int SLOT_W = ($clog2(K-1) > 0) ? $clog2(K-1) : 1,
  localparam int COL_W  = ($clog2(IMG_W) > 0) ? $clog2(IMG_W) : 1
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [SLOT_W-1:0]        slot_i,
  input  logic [COL_W-1:0]         col_i,
  input  logic [PIX_W-1:0]         data_i,
  output logic [(K-1)*PIX_W-1:0]   col_o
);

  logic [PIX_W-1:0] mem_q [K-1][IMG_W];
  logic [SLOT_W:0]  rd_slot;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[slot_i][col_i] <= data_i;
  end

  // The slot about to be written holds the oldest row, so reading starts there.
  always_comb begin
    col_o   = '0;
    rd_slot = '0;
    for (int j = 0; j < K-1; j++) begin
      rd_slot = {1'b0, slot_i} + (SLOT_W+1)'(j);
      if (rd_slot >= (SLOT_W+1)'(K-1)) rd_slot = rd_slot - (SLOT_W+1)'(K-1);
      col_o[j*PIX_W +: PIX_W] = mem_q[rd_slot[SLOT_W-1:0]][col_i];
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - raster pixel stream to KxK window feeder for the convolution core
// Optional WAIT-cycle counter enabled by CONV_WIN_PERF_CNT_EN.
module conv_window_gen
  import conv_win_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = CONV_K,
  parameter int PIX_W = CONV_PIX_W,
  localparam int WR_W = ($clog2(IMG_H-K+1) > 0) ? $clog2(IMG_H-K+1) : 1,
  localparam int WC_W = ($clog2(IMG_W-K+1) > 0) ? $clog2(IMG_W-K+1) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [PIX_W-1:0]       pix_in,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic [K*K*PIX_W-1:0]   win,
  output logic                   win_enable,
  input  logic                   core_valid,
  output logic [WR_W-1:0]        win_row,
  output logic [WC_W-1:0]        win_col,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            stall_cycles
);

  localparam int ROW_CW = ($clog2(IMG_H) > 0) ? $clog2(IMG_H) : 1;
  localparam int COL_CW = ($clog2(IMG_W) > 0) ? $clog2(IMG_W) : 1;
  localparam int SLOT_W = ($clog2(K-1) > 0) ? $clog2(K-1) : 1;
  localparam logic [ROW_CW-1:0] ROW_FIRST = ROW_CW'(K-1);
  localparam logic [ROW_CW-1:0] ROW_LAST  = ROW_CW'(IMG_H-1);
  localparam logic [COL_CW-1:0] COL_FIRST = COL_CW'(K-1);
  localparam logic [COL_CW-1:0] COL_LAST  = COL_CW'(IMG_W-1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(K-2);

  logic [2:0]               state_q, state_d;
  logic [ROW_CW-1:0]        row_q;
  logic [COL_CW-1:0]        col_q;
  logic [SLOT_W-1:0]        slot_q;
  logic [K*K*PIX_W-1:0]     win_q, win_d;
  logic [WR_W-1:0]          win_row_q;
  logic [WC_W-1:0]          win_col_q;
  logic                     last_q;
  logic [(K-1)*PIX_W-1:0]   lb_col;
  logic                     accept, win_full, eof;

  assign accept   = (state_q == ST_FILL) && pix_valid;
  assign win_full = (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
  assign eof      = (row_q == ROW_LAST) && (col_q == COL_LAST);

  conv_line_buf #(.IMG_W(IMG_W), .K(K), .PIX_W(PIX_W)) u_line_buf (
    .clk_i  (clk),
    .we_i   (accept),
    .slot_i (slot_q),
    .col_i  (col_q),
    .data_i (pix_in),
    .col_o  (lb_col)
  );

  // Shift left one column; the new right column is the buffered rows plus the live pixel.
  always_comb begin
    win_d = win_q;
    for (int ky = 0; ky < K; ky++) begin
      for (int kx = 0; kx < K-1; kx++)
        win_d[(ky*K+kx)*PIX_W +: PIX_W] = win_q[(ky*K+kx+1)*PIX_W +: PIX_W];
    end
    for (int ky = 0; ky < K-1; ky++)
      win_d[(ky*K+K-1)*PIX_W +: PIX_W] = lb_col[ky*PIX_W +: PIX_W];
    win_d[(K*K-1)*PIX_W +: PIX_W] = pix_in;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FILL;
      ST_FILL:  if (accept && win_full) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (core_valid) state_d = last_q ? ST_DONE : ST_FILL;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      slot_q    <= '0;
      win_q     <= '0;
      win_row_q <= '0;
      win_col_q <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        row_q  <= '0;
        col_q  <= '0;
        slot_q <= '0;
        last_q <= 1'b0;
      end
      if (accept) begin
        win_q <= win_d;
        if (win_full) begin
          win_row_q <= WR_W'(row_q - ROW_FIRST);
          win_col_q <= WC_W'(col_q - COL_FIRST);
          last_q    <= eof;
        end
        if (col_q == COL_LAST) begin
          col_q  <= '0;
          row_q  <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
          slot_q <= (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  assign pix_ready  = (state_q == ST_FILL);
  assign win_enable = (state_q == ST_ISSUE);
  assign done       = (state_q == ST_DONE);
  assign busy       = (state_q == ST_FILL) || (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign win        = win_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;

`ifdef CONV_WIN_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      stall_q <= '0;
    end else if (state_q == ST_WAIT && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - scoreboard bench for conv_window_gen on an 8x8 frame with K=7
module tb_conv_window_gen;

  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int KK    = 7;
  localparam int PW    = 8;
  localparam int WB    = KK*KK*PW;
  localparam int NPIX  = IMG_W*IMG_H;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          core_valid = 1'b0;
  logic          pix_ready, win_enable, busy, done;
  logic [WB-1:0] win;
  logic [0:0]    win_row, win_col;
  logic [31:0]   stall_cycles;

  conv_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(KK), .PIX_W(PW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .pix_in       (pix_in),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .win          (win),
    .win_enable   (win_enable),
    .core_valid   (core_valid),
    .win_row      (win_row),
    .win_col      (win_col),
    .busy         (busy),
    .done         (done),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WB-1:0] win;
    int            row;
    int            col;
  } exp_t;

  typedef struct {
    int delay;
    int cv_issue;
    int cv_fill;
    int start_busy;
    int abort_after;
    int exp_win;
  } tcase_t;

  exp_t   sb[$];
  tcase_t tc[6];
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_win(input string nm, input logic [WB-1:0] exp);
    checks++;
    if (win !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, win, exp);
    end
  endtask

  function automatic logic [PW-1:0] pixv(input int r, input int c);
    return PW'(r*8 + c);
  endfunction

  function automatic logic [WB-1:0] model_win(input int orow, input int ocol);
    logic [WB-1:0] w;
    w = '0;
    for (int ky = 0; ky < KK; ky++)
      for (int kx = 0; kx < KK; kx++)
        w[(ky*KK+kx)*PW +: PW] = pixv(orow+ky, ocol+kx);
    return w;
  endfunction

  task automatic run_frame(input int tno, input tcase_t t);
    int   idx = 0, cd = 0, nwin = 0, nack = 0, cyc = 0, lowcnt = 0, extra = 0;
    int   r, c, exp_stall;
    bit   xfer = 0, meas = 0, fin = 0, aborted = 0;
    exp_t cur, e;
    sb.delete();
`ifdef CONV_WIN_PERF_CNT_EN
    exp_stall = t.delay * t.exp_win;
`else
    exp_stall = 0;
`endif
    @(negedge clk);
    start = 1'b1; pix_valid = 1'b1; pix_in = pixv(0, 0); core_valid = 1'b0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (t.abort_after > 0 && nack == t.abort_after) begin
        rst_n = 1'b0; pix_valid = 1'b0; core_valid = 1'b0; start = 1'b0;
        #1;
        chk("rst_ctrl_outputs", 64'({busy, pix_ready, win_enable, done, win_row, win_col}), 64'd0);
        chk("rst_win_zero", 64'(|win), 64'd0);
        chk("rst_stall_zero", 64'(stall_cycles), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1;
        fin = 1;
        break;
      end
      start = (t.start_busy != 0 && idx == 20) ? 1'b1 : 1'b0;
      if (cyc == 1) chk("busy_after_start", 64'(busy), 64'd1);
      if (xfer) begin
        idx++;
        pix_valid = (idx < NPIX);
        pix_in = (idx < NPIX) ? pixv(idx / IMG_W, idx % IMG_W) : '0;
      end
      core_valid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          core_valid = 1'b1;
          nack++;
          chk_win($sformatf("t%0d_hold_win%0d", tno, nwin), cur.win);
          chk("hold_row_col", 64'({win_row, win_col}), 64'({cur.row[0], cur.col[0]}));
        end
      end
      if (t.cv_fill != 0 && pix_ready && (idx % 5) == 0) core_valid = 1'b1;
      if (meas) begin
        if (pix_ready) begin
          chk($sformatf("t%0d_ready_low_cycles", tno), 64'(lowcnt), 64'(t.delay + 1));
          meas = 0;
        end else begin
          lowcnt++;
        end
      end
      if (win_enable) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL t%0d_unexpected_window: got window %0d required none", tno, nwin);
        end else begin
          cur = sb.pop_front();
          chk_win($sformatf("t%0d_win%0d", tno, nwin), cur.win);
          chk("win_row", 64'(win_row), 64'(cur.row));
          chk("win_col", 64'(win_col), 64'(cur.col));
        end
        nwin++;
        cd = t.delay;
        meas = 1; lowcnt = 1;
        if (t.cv_issue != 0) core_valid = 1'b1;
      end
      xfer = pix_valid && pix_ready;
      if (xfer) begin
        r = idx / IMG_W; c = idx % IMG_W;
        if (r >= KK-1 && c >= KK-1) begin
          e.win = model_win(r-KK+1, c-KK+1);
          e.row = r-KK+1;
          e.col = c-KK+1;
          sb.push_back(e);
        end
      end
      if (done) begin
        chk($sformatf("t%0d_window_count", tno), 64'(nwin), 64'(t.exp_win));
        chk("pixels_consumed", 64'(idx), 64'(NPIX));
        chk("busy_at_done", 64'(busy), 64'd0);
        chk($sformatf("t%0d_stall_cycles", tno), 64'(stall_cycles), 64'(exp_stall));
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        fin = 1;
      end
      if (cyc > 3000) begin
        checks++; errors++;
        $display("FAIL t%0d_timeout: got no done after %0d cycles required done", tno, cyc);
        fin = 1;
      end
    end
    start = 1'b0; core_valid = 1'b0; pix_valid = 1'b0;
    if (!aborted) begin
      repeat (3) begin
        @(negedge clk);
        if (done || win_enable || busy) extra++;
      end
      chk($sformatf("t%0d_quiet_after_done", tno), 64'(extra), 64'd0);
    end
  endtask

  initial begin
    tc[0] = '{delay: 3,  cv_issue: 0, cv_fill: 0, start_busy: 0, abort_after: 0, exp_win: 4};
    tc[1] = '{delay: 10, cv_issue: 0, cv_fill: 0, start_busy: 0, abort_after: 0, exp_win: 4};
    tc[2] = '{delay: 3,  cv_issue: 1, cv_fill: 1, start_busy: 0, abort_after: 0, exp_win: 4};
    tc[3] = '{delay: 3,  cv_issue: 0, cv_fill: 0, start_busy: 0, abort_after: 2, exp_win: 4};
    tc[4] = '{delay: 3,  cv_issue: 0, cv_fill: 0, start_busy: 0, abort_after: 0, exp_win: 4};
    tc[5] = '{delay: 5,  cv_issue: 0, cv_fill: 0, start_busy: 1, abort_after: 0, exp_win: 4};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl_outputs", 64'({busy, pix_ready, win_enable, done, win_row, win_col}), 64'd0);
    chk("reset_win_zero", 64'(|win), 64'd0);
    chk("reset_stall_zero", 64'(stall_cycles), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_not_ready", 64'(pix_ready), 64'd0);

    for (int i = 0; i < 6; i++) run_frame(i, tc[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no summary by 200000 required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
